instr_fetch_unit: RTL and testbench

- Upstream fetch stage for the single-cycle MIPS datapath.
- Takes the datapath's `pc` and fetches the instruction word from a variable-latency instruction memory using a req/gnt/rvalid handshake.
- Presents a stable `instr` to the datapath and pulses `cpu_enable` (wired to the datapath `enable`) for exactly one cycle per instruction.
- Also provides data-memory stall gating, a sticky fetch-error flag and a retired-instruction counter.

---
 rtl/instr_fetch_unit_if.sv | 26 ++
 rtl/instr_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface instr_fetch_unit_if #(
    parameter int unsigned Dbits = 32
);
    logic             imem_req;
    logic [Dbits-1:0] imem_addr;
    logic             imem_gnt;
    logic             imem_rvalid;
    logic [Dbits-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage for the single-cycle MIPS datapath: fetches the word at pc over a
// req/gnt/rvalid bus, presents it on instr and pulses cpu_enable once per
// instruction. Also tracks a sticky fetch error and a retired-instruction count.
module instr_fetch_unit #(
    parameter int unsigned Dbits   = 32,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNTW    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [Dbits-1:0]    pc,
    output logic [Dbits-1:0]    instr,
    output logic                cpu_enable,
    input  logic                dmem_stall,
    instr_fetch_unit_if.master  imem,
    output logic                fetch_err,
    output logic [Dbits-1:0]    err_pc,
    output logic [CNTW-1:0]     instret
);

    localparam int unsigned TCNT_W = 8;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        EXEC = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [TCNT_W-1:0]   r_tcnt;
    logic                w_aligned;
    logic                w_capture;
    logic                w_err_set;
    logic                w_tcnt_clr;
    logic                w_tcnt_inc;
    logic                w_retire;

    assign w_aligned = (pc[1:0] == 2'b00);

    // State register; reset returns to IDLE from anywhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus the combinational bus/strobe outputs.
    always_comb begin
        w_next          = r_state;
        cpu_enable      = 1'b0;
        imem.imem_req   = 1'b0;
        imem.imem_addr  = '0;
        w_capture       = 1'b0;
        w_err_set       = 1'b0;
        w_tcnt_clr      = 1'b0;
        w_tcnt_inc      = 1'b0;
        w_retire        = 1'b0;
        case (r_state)
            IDLE: begin
                w_next = REQ;
            end
            REQ: begin
                if (!w_aligned) begin
                    w_err_set = 1'b1;
                    w_next    = ERR;
                end else begin
                    imem.imem_req  = 1'b1;
                    imem.imem_addr = pc;
                    if (imem.imem_gnt) begin
                        if (imem.imem_rvalid) begin
                            w_capture = 1'b1;
                            w_next    = EXEC;
                        end else begin
                            w_tcnt_clr = 1'b1;
                            w_next     = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                // A response on the final timeout cycle still wins.
                if (imem.imem_rvalid) begin
                    w_capture = 1'b1;
                    w_next    = EXEC;
                end else if (r_tcnt == TCNT_LAST) begin
                    w_err_set = 1'b1;
                    w_next    = ERR;
                end else begin
                    w_tcnt_inc = 1'b1;
                end
            end
            EXEC: begin
                cpu_enable = ~dmem_stall;
                if (!dmem_stall) begin
                    w_retire = 1'b1;
                    w_next   = REQ;
                end
            end
            ERR: begin
                w_next = ERR;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Instruction capture, error latch, timeout counter and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr     <= '0;
            fetch_err <= 1'b0;
            err_pc    <= '0;
            r_tcnt    <= '0;
            instret   <= '0;
        end else begin
            if (w_capture) begin
                instr <= imem.imem_rdata;
            end
            if (w_err_set) begin
                fetch_err <= 1'b1;
                err_pc    <= pc;
            end
            if (w_tcnt_clr) begin
                r_tcnt <= '0;
            end else if (w_tcnt_inc) begin
                r_tcnt <= r_tcnt + TCNT_W'(1);
            end
            if (w_retire) begin
                instret <= instret + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// fetches scored against a transaction-level timing model.
module tb_instr_fetch_unit;

    localparam int unsigned DW  = 32;
    localparam int unsigned TO  = 16;
    localparam int unsigned CW  = 32;

    logic          clk;
    logic          reset;
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
    logic          cpu_enable;
    logic          dmem_stall;
    logic          fetch_err;
    logic [DW-1:0] err_pc;
    logic [CW-1:0] instret;

    instr_fetch_unit_if #(.Dbits(DW)) u_if ();

    instr_fetch_unit #(.Dbits(DW), .TIMEOUT(TO), .CNTW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .instr      (instr),
        .cpu_enable (cpu_enable),
        .dmem_stall (dmem_stall),
        .imem       (u_if),
        .fetch_err  (fetch_err),
        .err_pc     (err_pc),
        .instret    (instret)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model of architecturally visible state.
    logic [DW-1:0] m_instr;
    logic [CW-1:0] m_instret;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        u_if.imem_gnt    = 1'b0;
        u_if.imem_rvalid = 1'b0;
        u_if.imem_rdata  = '0;
        dmem_stall       = 1'b0;
    endtask

    // Reset for one cycle, check reset values, then the IDLE bubble and REQ.
    task automatic test_reset(input logic [DW-1:0] a_pc);
        reset = 1'b1;
        pc    = a_pc;
        idle_inputs();
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (instr !== '0 || cpu_enable !== 1'b0 || u_if.imem_req !== 1'b0 ||
            u_if.imem_addr !== '0 || fetch_err !== 1'b0 || err_pc !== '0 || instret !== '0) begin
            n_errors++;
            $display("FAIL reset_values: instr=%h en=%b req=%b addr=%h err=%b err_pc=%h instret=%0d, required all zero",
                     instr, cpu_enable, u_if.imem_req, u_if.imem_addr, fetch_err, err_pc, instret);
        end
        m_instr   = '0;
        m_instret = '0;
        tick();
        #1;
        n_checks++;
        if (u_if.imem_req !== 1'b1 || u_if.imem_addr !== a_pc) begin
            n_errors++;
            $display("FAIL reset_bubble_req: req=%b addr=%h, required req=1 addr=%h",
                     u_if.imem_req, u_if.imem_addr, a_pc);
        end
    endtask

    // One fetch: memory grants after g request cycles, answers lat cycles after
    // the grant (0 = same cycle), datapath stalls s cycles in execute.
    // Starts and ends at the negedge of a REQ cycle.
    task automatic test_fetch(input logic [DW-1:0] a_pc, input logic [DW-1:0] a_data,
                              input int g, input int lat, input int s);
        int  cyc;
        int  req_seen;
        int  req_total;
        int  since_gnt;
        int  since_cap;
        int  pulse_cyc;
        int  exp_pulse;
        bit  granted;
        bit  captured;
        bit  cap_now;
        bit  addr_bad;
        bit  instr_bad;
        bit  err_bad;
        cyc = 0; req_seen = 0; req_total = 0; since_gnt = 0; since_cap = 0;
        pulse_cyc = -1; granted = 0; captured = 0;
        addr_bad = 0; instr_bad = 0; err_bad = 0;
        exp_pulse = g + 1 + lat + s;
        while (pulse_cyc < 0 && cyc < 300) begin
            pc = a_pc;
            idle_inputs();
            cap_now = 0;
            dmem_stall = captured && (since_cap < s);
            #1;
            if (u_if.imem_req === 1'b1) begin
                req_total++;
                if (u_if.imem_addr !== a_pc) addr_bad = 1;
            end
            if (fetch_err !== 1'b0) err_bad = 1;
            if (captured ? (instr !== a_data) : (instr !== m_instr)) instr_bad = 1;
            if (cpu_enable === 1'b1) pulse_cyc = cyc;
            if (!granted && u_if.imem_req === 1'b1) begin
                if (req_seen == g) begin
                    u_if.imem_gnt = 1'b1;
                    granted = 1;
                    since_gnt = 0;
                    if (lat == 0) begin
                        u_if.imem_rvalid = 1'b1;
                        u_if.imem_rdata  = a_data;
                        cap_now = 1;
                    end
                end else begin
                    // Response without grant must be ignored.
                    u_if.imem_rvalid = 1'($urandom_range(0, 1));
                    u_if.imem_rdata  = $urandom;
                end
                req_seen++;
            end else if (granted && !captured && lat > 0) begin
                since_gnt++;
                if (since_gnt == lat) begin
                    u_if.imem_rvalid = 1'b1;
                    u_if.imem_rdata  = a_data;
                    cap_now = 1;
                end
            end
            @(posedge clk);
            if (captured) since_cap++;
            if (cap_now) begin
                captured = 1;
                since_cap = 0;
            end
            cyc++;
            @(negedge clk);
        end
        idle_inputs();
        #1;
        n_checks++;
        if (pulse_cyc != exp_pulse) begin
            n_errors++;
            $display("FAIL fetch_pulse_cycle pc=%h: pulse at cycle %0d, required %0d", a_pc, pulse_cyc, exp_pulse);
        end
        n_checks++;
        if (req_total != g + 1 || addr_bad) begin
            n_errors++;
            $display("FAIL fetch_req pc=%h: req cycles=%0d addr_bad=%0b, required %0d cycles at pc",
                     a_pc, req_total, addr_bad, g + 1);
        end
        n_checks++;
        if (instr_bad || instr !== a_data) begin
            n_errors++;
            $display("FAIL fetch_instr pc=%h: instr=%h (glitch=%0b), required %h", a_pc, instr, instr_bad, a_data);
        end
        n_checks++;
        if (instret !== m_instret + CW'(1)) begin
            n_errors++;
            $display("FAIL fetch_instret pc=%h: instret=%0d, required %0d", a_pc, instret, m_instret + CW'(1));
        end
        n_checks++;
        if (err_bad || fetch_err !== 1'b0) begin
            n_errors++;
            $display("FAIL fetch_no_err pc=%h: fetch_err=%b, required 0", a_pc, fetch_err);
        end
        m_instr   = a_data;
        m_instret = m_instret + CW'(1);
    endtask

    // Grant with no response: error after TIMEOUT wait cycles, then absorbing.
    task automatic test_timeout(input logic [DW-1:0] a_pc);
        pc = a_pc;
        idle_inputs();
        u_if.imem_gnt = 1'b1;
        #1;
        n_checks++;
        if (u_if.imem_req !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_req: req=%b, required 1", u_if.imem_req);
        end
        tick();
        idle_inputs();
        for (int k = 1; k <= TO + 1; k++) begin
            #1;
            if (k == TO) begin
                n_checks++;
                if (fetch_err !== 1'b0) begin
                    n_errors++;
                    $display("FAIL timeout_early: fetch_err=%b at wait cycle %0d, required 0", fetch_err, k);
                end
            end
            if (k == TO + 1) begin
                n_checks++;
                if (fetch_err !== 1'b1 || err_pc !== a_pc) begin
                    n_errors++;
                    $display("FAIL timeout_err: fetch_err=%b err_pc=%h, required 1 and %h", fetch_err, err_pc, a_pc);
                end
            end
            if (k <= TO) tick();
        end
        for (int k = 0; k < 4; k++) begin
            u_if.imem_rvalid = 1'b1;
            u_if.imem_rdata  = $urandom;
            u_if.imem_gnt    = 1'($urandom_range(0, 1));
            tick();
            #1;
            n_checks++;
            if (instr !== m_instr || cpu_enable !== 1'b0 || u_if.imem_req !== 1'b0 || fetch_err !== 1'b1) begin
                n_errors++;
                $display("FAIL timeout_absorb: instr=%h en=%b req=%b err=%b, required %h 0 0 1",
                         instr, cpu_enable, u_if.imem_req, fetch_err, m_instr);
            end
        end
        idle_inputs();
    endtask

    // Misaligned pc: no request, error latched with the offending pc.
    task automatic test_misaligned(input logic [DW-1:0] a_pc);
        bit req_seen;
        req_seen = 0;
        pc = a_pc;
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            u_if.imem_gnt    = 1'b1;
            u_if.imem_rvalid = 1'b1;
            u_if.imem_rdata  = $urandom;
            #1;
            if (u_if.imem_req !== 1'b0 || cpu_enable !== 1'b0) req_seen = 1;
            tick();
        end
        #1;
        n_checks++;
        if (req_seen || fetch_err !== 1'b1 || err_pc !== a_pc || instr !== m_instr) begin
            n_errors++;
            $display("FAIL misaligned: req_or_en_seen=%0b err=%b err_pc=%h instr=%h, required 0 1 %h %h",
                     req_seen, fetch_err, err_pc, instr, a_pc, m_instr);
        end
        idle_inputs();
    endtask

    // Reset while waiting on a response: everything returns to reset values.
    task automatic test_reset_mid_wait(input logic [DW-1:0] a_pc);
        pc = a_pc;
        idle_inputs();
        u_if.imem_gnt = 1'b1;
        tick();
        idle_inputs();
        tick();
        n_checks++;
        if (instret === '0 || u_if.imem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_wait_setup: instret=%0d req=%b, required nonzero and 0", instret, u_if.imem_req);
        end
        test_reset(a_pc);
    endtask

    initial begin
        reset = 1'b1;
        pc    = '0;
        idle_inputs();
        m_instr   = '0;
        m_instret = '0;
        repeat (2) @(negedge clk);

        test_reset(32'h0040_0000);
        test_fetch(32'h0040_0000, 32'h2008_0005, 0, 0, 0);
        test_fetch(32'h0040_0004, 32'h8C09_0000, 0, 3, 0);
        test_fetch(32'h0040_0008, 32'h0128_5020, 0, 0, 4);
        test_fetch(32'h0040_000C, 32'hAC0A_0004, 2, TO, 1);
        test_fetch(32'h0040_0010, 32'h1000_FFFF, 1, TO - 1, 0);

        for (int i = 0; i < 24; i++) begin
            test_fetch(32'h0040_0000 + 32'(i * 4 + 20), $urandom,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                       int'($urandom_range(0, 3)));
        end

        test_reset_mid_wait(32'h0040_0100);
        test_fetch(32'h0040_0100, 32'h3C01_1001, 0, 1, 2);
        test_timeout(32'h0040_0104);

        test_reset(32'h0040_0200);
        test_fetch(32'h0040_0200, 32'h0000_000C, 0, 0, 0);
        pc = 32'h0040_0002;
        test_misaligned(32'h0040_0002);

        test_reset(32'h0040_0300);
        test_fetch(32'h0040_0300, 32'h2402_000A, 1, 2, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
